xcore_cmt_buf: RTL and testbench

- Parametrised commit stage with a DEPTH-entry write-back queue between EX and WB.
- Decouples WB stalls from EX: results already complete in EX are enqueued and retired in order, without holding the pipe.
- Commit happens exactly once per instruction through a valid/accept handshake, so no separate "committed" flag is needed.
- Issues branch-flush and predictor-update pulses on the commit cycle and keeps a retired-instruction counter.

---
 rtl/xcore_cmt_buf_if.sv | 72 +++++++
 rtl/xcore_cmt_buf.sv | 122 ++++++++++++
 tb/tb_xcore_cmt_buf.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xcore_cmt_buf_if.sv
// Commit-stage bundle: EX results, branch resolution and write-back handshake.
// Latency: none (wiring only).
// Backpressure: i_wb_rdy from WB; o_cmt_stall_req back to IF/ID/EX.
// Ports: i_* come from EX/BJP/LSU/WB into the commit stage; o_* leave it.
// Modports: master = pipeline/WB side that drives i_*, slave = commit stage.
interface xcore_cmt_buf_if #(
    parameter int XLEN  = 32,
    parameter int ID_W  = 3,
    parameter int CNT_W = 32
);
    logic            i_ex_instr_vld;
    logic [XLEN-1:0] i_ex_instr_pc;
    logic [4:0]      i_ex_rd_addr;
    logic            i_ex_alu_req;
    logic            i_ex_bjp_req;
    logic            i_ex_csr_req;
    logic            i_ex_sys_req;
    logic            i_ex_lsu_req;
    logic [XLEN-1:0] i_ex_alu_res;
    logic [XLEN-1:0] i_bjp_res;
    logic [XLEN-1:0] i_ex_csr;
    logic [XLEN-1:0] i_lsu_res;
    logic            i_lsu_vld;
    logic            i_ex_csr_wr;
    logic [11:0]     i_ex_csr_addr;
    logic [XLEN-1:0] i_ex_csr_wdata;
    logic            i_bjp_flush_req;
    logic            i_bjp_flush_type;
    logic [ID_W-1:0] i_bjp_flush_id;
    logic [XLEN-1:0] i_bjp_target;
    logic            i_wb_rdy;

    logic             o_cmt_stall_req;
    logic             o_cmt_accept;
    logic             o_cmt_flush_req;
    logic             o_cmt_flush_type;
    logic [ID_W-1:0]  o_cmt_flush_id;
    logic             o_cmt_bjp_upd;
    logic [XLEN-1:0]  o_cmt_bjp_target;
    logic             o_wb_vld;
    logic             o_wb_rd_we;
    logic [4:0]       o_wb_rd_addr;
    logic [XLEN-1:0]  o_wb_rd_data;
    logic             o_wb_csr_we;
    logic [11:0]      o_wb_csr_addr;
    logic [XLEN-1:0]  o_wb_csr_data;
    logic [CNT_W-1:0] o_cmt_cnt;

    modport master (
        output i_ex_instr_vld, i_ex_instr_pc, i_ex_rd_addr,
               i_ex_alu_req, i_ex_bjp_req, i_ex_csr_req, i_ex_sys_req, i_ex_lsu_req,
               i_ex_alu_res, i_bjp_res, i_ex_csr, i_lsu_res, i_lsu_vld,
               i_ex_csr_wr, i_ex_csr_addr, i_ex_csr_wdata,
               i_bjp_flush_req, i_bjp_flush_type, i_bjp_flush_id, i_bjp_target, i_wb_rdy,
        input  o_cmt_stall_req, o_cmt_accept, o_cmt_flush_req, o_cmt_flush_type,
               o_cmt_flush_id, o_cmt_bjp_upd, o_cmt_bjp_target,
               o_wb_vld, o_wb_rd_we, o_wb_rd_addr, o_wb_rd_data,
               o_wb_csr_we, o_wb_csr_addr, o_wb_csr_data, o_cmt_cnt
    );

    modport slave (
        input  i_ex_instr_vld, i_ex_instr_pc, i_ex_rd_addr,
               i_ex_alu_req, i_ex_bjp_req, i_ex_csr_req, i_ex_sys_req, i_ex_lsu_req,
               i_ex_alu_res, i_bjp_res, i_ex_csr, i_lsu_res, i_lsu_vld,
               i_ex_csr_wr, i_ex_csr_addr, i_ex_csr_wdata,
               i_bjp_flush_req, i_bjp_flush_type, i_bjp_flush_id, i_bjp_target, i_wb_rdy,
        output o_cmt_stall_req, o_cmt_accept, o_cmt_flush_req, o_cmt_flush_type,
               o_cmt_flush_id, o_cmt_bjp_upd, o_cmt_bjp_target,
               o_wb_vld, o_wb_rd_we, o_wb_rd_addr, o_wb_rd_data,
               o_wb_csr_we, o_wb_csr_addr, o_wb_csr_data, o_cmt_cnt
    );
endinterface

// File: rtl/xcore_cmt_buf.sv
// Commit stage: accepts finished EX results into a DEPTH-entry in-order write-back queue.
// Latency: 1 cycle accept -> o_wb_vld when empty (0 cycles with XCORE_CMT_BYPASS_EN).
// Backpressure: i_wb_rdy drains the head; queue full raises o_cmt_stall_req to hold EX.
// Ports: i_sys_clk, i_sys_rst_n (async active-low), bus (xcore_cmt_buf_if.slave).
// Optional feature macro: XCORE_CMT_BYPASS_EN -- empty queue with WB ready forwards
// the accepted entry straight to o_wb_* in the same cycle without touching the queue.
module xcore_cmt_buf #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int ID_W  = 3,
    parameter int CNT_W = 32
) (
    input logic            i_sys_clk,
    input logic            i_sys_rst_n,
    xcore_cmt_buf_if.slave bus
);
    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic            rd_we;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_data;
        logic            csr_we;
        logic [11:0]     csr_addr;
        logic [XLEN-1:0] csr_data;
    } ent_t;

    ent_t             mem [DEPTH];
    ent_t             new_ent;
    ent_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [CNT_W-1:0] cmt_cnt;
    logic             done;
    logic             full;
    logic             accept;
    logic             byp;
    logic             enq;
    logic             deq;
    logic             head_vld;
    logic             wb_vld;
    logic             unused_pc;

    // The PC is carried by EX for debug/trace only; write-back has no use for it.
    assign unused_pc = ^bus.i_ex_instr_pc;

    assign done = bus.i_ex_alu_req | bus.i_ex_bjp_req | bus.i_ex_csr_req | bus.i_ex_sys_req
                | (bus.i_ex_lsu_req & bus.i_lsu_vld);
    // Full comes from the registered count: a same-cycle dequeue does not open a slot.
    assign full   = (count == FULL_CNT);
    assign accept = bus.i_ex_instr_vld & done & ~full;

    assign bus.o_cmt_accept    = accept;
    assign bus.o_cmt_stall_req = bus.i_ex_instr_vld & ~accept;

    // EX holds its inputs while stalled, so gating with accept yields single-cycle pulses.
    assign bus.o_cmt_flush_req   = accept & bus.i_bjp_flush_req;
    assign bus.o_cmt_flush_type  = bus.i_bjp_flush_type;
    assign bus.o_cmt_flush_id    = bus.i_bjp_flush_id;
    assign bus.o_cmt_bjp_upd     = accept & bus.i_ex_bjp_req;
    assign bus.o_cmt_bjp_target  = bus.i_bjp_target;

    always_comb begin
        new_ent          = '0;
        new_ent.rd_we    = (bus.i_ex_rd_addr != 5'd0) & ~bus.i_ex_sys_req;
        new_ent.rd_addr  = bus.i_ex_rd_addr;
        if (bus.i_ex_lsu_req)      new_ent.rd_data = bus.i_lsu_res;
        else if (bus.i_ex_csr_req) new_ent.rd_data = bus.i_ex_csr;
        else if (bus.i_ex_bjp_req) new_ent.rd_data = bus.i_bjp_res;
        else                       new_ent.rd_data = bus.i_ex_alu_res;
        new_ent.csr_we   = bus.i_ex_csr_req & bus.i_ex_csr_wr;
        new_ent.csr_addr = bus.i_ex_csr_addr;
        new_ent.csr_data = bus.i_ex_csr_wdata;
    end

`ifdef XCORE_CMT_BYPASS_EN
    assign byp = (count == '0) & bus.i_wb_rdy;
`else
    assign byp = 1'b0;
`endif

    assign enq      = accept & ~byp;
    assign head_vld = (count != '0);
    assign deq      = head_vld & bus.i_wb_rdy;
    assign wb_vld   = head_vld | (byp & accept);
    assign head     = byp ? new_ent : mem[rd_ptr];

    assign bus.o_wb_vld      = wb_vld;
    assign bus.o_wb_rd_we    = head.rd_we;
    assign bus.o_wb_rd_addr  = head.rd_addr;
    assign bus.o_wb_rd_data  = head.rd_data;
    assign bus.o_wb_csr_we   = head.csr_we;
    assign bus.o_wb_csr_addr = head.csr_addr;
    assign bus.o_wb_csr_data = head.csr_data;
    assign bus.o_cmt_cnt     = cmt_cnt;

    // Queue storage is not reset: validity is carried entirely by count.
    always_ff @(posedge i_sys_clk) begin
        if (enq) mem[wr_ptr] <= new_ent;
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            cmt_cnt <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
            // Bypassed commits retire without a dequeue, so count the WB handshake.
            if (wb_vld & bus.i_wb_rdy) cmt_cnt <= cmt_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_xcore_cmt_buf.sv
// Bench for xcore_cmt_buf: directed commits, scoreboard checked by a WB-side monitor.
// Latency: expectations cover both the queued and the XCORE_CMT_BYPASS_EN builds.
// Backpressure: i_wb_rdy is held low to fill the queue and force EX stalls.
module tb_xcore_cmt_buf;
    localparam int XLEN = 32, DEPTH = 2, ID_W = 3, CNT_W = 32;
    localparam int U_ALU = 0, U_BJP = 1, U_CSR = 2, U_SYS = 3, U_LSU = 4;

    typedef struct packed {
        logic        rd_we;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic        csr_we;
        logic [11:0] csr_addr;
        logic [31:0] csr_data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xcore_cmt_buf_if #(.XLEN(XLEN), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

    xcore_cmt_buf #(.XLEN(XLEN), .DEPTH(DEPTH), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .i_sys_clk   (clk),
        .i_sys_rst_n (rst_n),
        .bus         (bus.slave)
    );

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_cnt = '0;
`ifdef XCORE_CMT_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.i_ex_instr_vld   = 1'b0;
        bus.i_ex_instr_pc    = '0;
        bus.i_ex_rd_addr     = '0;
        bus.i_ex_alu_req     = 1'b0;
        bus.i_ex_bjp_req     = 1'b0;
        bus.i_ex_csr_req     = 1'b0;
        bus.i_ex_sys_req     = 1'b0;
        bus.i_ex_lsu_req     = 1'b0;
        bus.i_ex_alu_res     = '0;
        bus.i_bjp_res        = '0;
        bus.i_ex_csr         = '0;
        bus.i_lsu_res        = '0;
        bus.i_lsu_vld        = 1'b0;
        bus.i_ex_csr_wr      = 1'b0;
        bus.i_ex_csr_addr    = '0;
        bus.i_ex_csr_wdata   = '0;
        bus.i_bjp_flush_req  = 1'b0;
        bus.i_bjp_flush_type = 1'b0;
        bus.i_bjp_flush_id   = '0;
        bus.i_bjp_target     = '0;
    endtask

    // Presents one instruction and holds it until accepted; returns at posedge+1.
    task automatic issue(input int unit, input logic [4:0] rd, input logic [31:0] res,
                         input logic csr_wr, input logic [11:0] caddr, input logic [31:0] cdata,
                         input logic flush, input logic [2:0] fid, input int lsu_delay,
                         output int stalls, output logic vld_at_acc);
        bit   acc;
        exp_t e;
        acc = 0;
        stalls = 0;
        vld_at_acc = 1'b0;
        bus.i_ex_instr_vld   = 1'b1;
        bus.i_ex_instr_pc    = 32'h100 + 32'(rd);
        bus.i_ex_rd_addr     = rd;
        bus.i_ex_alu_req     = (unit == U_ALU);
        bus.i_ex_bjp_req     = (unit == U_BJP);
        bus.i_ex_csr_req     = (unit == U_CSR);
        bus.i_ex_sys_req     = (unit == U_SYS);
        bus.i_ex_lsu_req     = (unit == U_LSU);
        bus.i_ex_alu_res     = 32'hA1A1_0000;
        bus.i_bjp_res        = 32'hB2B2_0000;
        bus.i_ex_csr         = 32'hC3C3_0000;
        bus.i_lsu_res        = 32'hD4D4_0000;
        case (unit)
            U_BJP:   bus.i_bjp_res    = res;
            U_CSR:   bus.i_ex_csr     = res;
            U_LSU:   bus.i_lsu_res    = res;
            default: bus.i_ex_alu_res = res;
        endcase
        bus.i_ex_csr_wr      = csr_wr;
        bus.i_ex_csr_addr    = caddr;
        bus.i_ex_csr_wdata   = cdata;
        bus.i_bjp_flush_req  = flush;
        bus.i_bjp_flush_type = fid[0];
        bus.i_bjp_flush_id   = fid;
        bus.i_bjp_target     = 32'h8000_0000 | res;
        e.rd_we    = (rd != 5'd0) && (unit != U_SYS);
        e.rd_addr  = rd;
        e.rd_data  = res;
        e.csr_we   = (unit == U_CSR) && csr_wr;
        e.csr_addr = caddr;
        e.csr_data = cdata;
        for (int c = 0; c < 100 && !acc; c++) begin
            bus.i_lsu_vld = (unit == U_LSU) && (c >= lsu_delay);
            @(negedge clk);
            if (bus.o_cmt_accept) begin
                acc = 1;
                sb.push_back(e);
                vld_at_acc = bus.o_wb_vld;
                chk("stall_on_accept", bus.o_cmt_stall_req, 0);
                chk("flush_req", bus.o_cmt_flush_req, flush);
                if (flush) begin
                    chk("flush_id", bus.o_cmt_flush_id, fid);
                    chk("flush_type", bus.o_cmt_flush_type, fid[0]);
                end
                chk("bjp_upd", bus.o_cmt_bjp_upd, unit == U_BJP);
                if (unit == U_BJP) chk("bjp_target", bus.o_cmt_bjp_target, 32'h8000_0000 | res);
            end else begin
                stalls++;
                chk("stall_req", bus.o_cmt_stall_req, 1);
                chk("flush_while_stalled", bus.o_cmt_flush_req, 0);
            end
            @(posedge clk); #1;
        end
        idle();
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
        end
    endtask

    task automatic release_rdy(input int n);
        repeat (n) @(posedge clk);
        #1 bus.i_wb_rdy = 1'b1;
    endtask

    task automatic drain();
        bus.i_wb_rdy = 1'b1;
        for (int c = 0; c < 50 && sb.size() != 0; c++) @(posedge clk);
        #1;
        chk("drain_left", 64'(sb.size()), 0);
    endtask

    // WB-side monitor: every head handshake pops the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk); #1;
            if (rst_n && bus.o_wb_vld && bus.i_wb_rdy) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL wb_unexpected: got rd_addr %0h expected no retire", bus.o_wb_rd_addr);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wb_rd_we", bus.o_wb_rd_we, e.rd_we);
                    chk("wb_rd_addr", bus.o_wb_rd_addr, e.rd_addr);
                    chk("wb_rd_data", bus.o_wb_rd_data, e.rd_data);
                    chk("wb_csr_we", bus.o_wb_csr_we, e.csr_we);
                    chk("wb_csr_addr", bus.o_wb_csr_addr, e.csr_addr);
                    chk("wb_csr_data", bus.o_wb_csr_data, e.csr_data);
                    chk("cmt_cnt_at_retire", bus.o_cmt_cnt, exp_cnt);
                    exp_cnt++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        int   st;
        logic va;
        idle();
        bus.i_wb_rdy = 1'b0;
        #2;
        chk("rst_wb_vld", bus.o_wb_vld, 0);
        chk("rst_cmt_cnt", bus.o_cmt_cnt, 0);
        chk("rst_accept", bus.o_cmt_accept, 0);
        chk("rst_flush", bus.o_cmt_flush_req, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.i_wb_rdy = 1'b1;
        @(posedge clk); #1;

        // Single ALU commit with WB ready.
        issue(U_ALU, 5'd5, 32'h1234, 1'b0, 12'h0, 32'h0, 1'b0, 3'd0, 0, st, va);
        chk("alu_stalls", st, 0);
        chk("alu_vld_same_cycle", va, BYP);
        @(negedge clk);
        if (!BYP) begin
            chk("alu_vld_next", bus.o_wb_vld, 1);
            chk("alu_rd_addr_next", bus.o_wb_rd_addr, 5);
            chk("alu_rd_data_next", bus.o_wb_rd_data, 32'h1234);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("alu_cnt_after", bus.o_cmt_cnt, 1);
        chk("alu_vld_empty", bus.o_wb_vld, 0);
        @(posedge clk); #1;

        // Load whose data arrives after 3 cycles.
        issue(U_LSU, 5'd7, 32'hDEAD, 1'b0, 12'h0, 32'h0, 1'b0, 3'd0, 3, st, va);
        chk("lsu_stalls", st, 3);
        drain();

        // Queue fills with WB stalled; third instruction waits for a slot.
        bus.i_wb_rdy = 1'b0;
        issue(U_ALU, 5'd1, 32'h11, 1'b0, 12'h0, 32'h0, 1'b0, 3'd0, 0, st, va);
        chk("fill_a_stalls", st, 0);
        issue(U_ALU, 5'd2, 32'h22, 1'b0, 12'h0, 32'h0, 1'b0, 3'd0, 0, st, va);
        chk("fill_b_stalls", st, 0);
        fork
            issue(U_ALU, 5'd3, 32'h33, 1'b0, 12'h0, 32'h0, 1'b0, 3'd0, 0, st, va);
            release_rdy(2);
        join
        chk("fill_c_stalls", st, 3);
        drain();

        // Mispredicted branch held behind a full queue.
        bus.i_wb_rdy = 1'b0;
        issue(U_ALU, 5'd8, 32'h88, 1'b0, 12'h0, 32'h0, 1'b0, 3'd0, 0, st, va);
        issue(U_ALU, 5'd9, 32'h99, 1'b0, 12'h0, 32'h0, 1'b0, 3'd0, 0, st, va);
        fork
            issue(U_BJP, 5'd1, 32'h2004, 1'b0, 12'h0, 32'h0, 1'b1, 3'd3, 0, st, va);
            release_rdy(1);
        join
        chk("bjp_stalls", st, 2);
        @(negedge clk);
        chk("flush_pulse_end", bus.o_cmt_flush_req, 0);
        chk("bjp_upd_end", bus.o_cmt_bjp_upd, 0);
        @(posedge clk); #1;
        drain();

        // Write-enable gating: rd=0, CSR with/without write, SYS, ALU with stray csr_wr.
        issue(U_ALU, 5'd0, 32'h77, 1'b0, 12'h0, 32'h0, 1'b0, 3'd0, 0, st, va);
        issue(U_CSR, 5'd6, 32'hC0DE, 1'b1, 12'h300, 32'h1888, 1'b0, 3'd0, 0, st, va);
        issue(U_CSR, 5'd6, 32'hBEEF, 1'b0, 12'h305, 32'h4444, 1'b0, 3'd0, 0, st, va);
        issue(U_SYS, 5'd4, 32'h5555, 1'b0, 12'h0, 32'h0, 1'b0, 3'd0, 0, st, va);
        issue(U_ALU, 5'd10, 32'h6666, 1'b1, 12'h300, 32'h7, 1'b0, 3'd0, 0, st, va);
        drain();

        // Reset with two queued entries discards them immediately.
        bus.i_wb_rdy = 1'b0;
        issue(U_ALU, 5'd10, 32'hA, 1'b0, 12'h0, 32'h0, 1'b0, 3'd0, 0, st, va);
        issue(U_ALU, 5'd11, 32'hB, 1'b0, 12'h0, 32'h0, 1'b0, 3'd0, 0, st, va);
        @(negedge clk);
        chk("pre_rst_vld", bus.o_wb_vld, 1);
        chk("pre_rst_cnt", bus.o_cmt_cnt, exp_cnt);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_wb_vld", bus.o_wb_vld, 0);
        chk("midrst_cmt_cnt", bus.o_cmt_cnt, 0);
        sb.delete();
        exp_cnt = '0;
        bus.i_wb_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_vld", bus.o_wb_vld, 0);
        @(posedge clk); #1;
        issue(U_ALU, 5'd12, 32'h5A5A, 1'b0, 12'h0, 32'h0, 1'b0, 3'd0, 0, st, va);
        chk("post_rst_vld_same_cycle", va, BYP);
        drain();
        @(negedge clk);
        chk("post_rst_cnt", bus.o_cmt_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
